// File: rtl/sr_latch_pkg.sv
// sr_latch_pkg: mode and command encodings shared by the SR latch bank
package sr_latch_pkg;
    localparam int MODE_NAND    = 0;
    localparam int MODE_SET_DOM = 1;
    localparam int MODE_CLR_DOM = 2;
    localparam int MODE_TOGGLE  = 3;
    localparam logic [1:0] CMD_IDLE = 2'b11;
    localparam logic [1:0] CMD_SET  = 2'b01;
    localparam logic [1:0] CMD_CLR  = 2'b10;
    localparam logic [1:0] CMD_BOTH = 2'b00;
endpackage

// File: rtl/sr_latch_channel.sv
// sr_latch_channel: one filtered SR state bit with both-asserted policy and status flags
module sr_latch_channel import sr_latch_pkg::*; #(
    parameter int FILTER_CYCLES = 3,
    parameter int MODE = MODE_NAND
) (
    input  logic clk,
    input  logic reset,
    input  logic set_n,
    input  logic clr_n,
    output logic q,
    output logic q_n,
    output logic changed,
    output logic invalid
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] FMAX = CW'(FILTER_CYCLES);
    logic [1:0] raw, pending, cmd, cmd_nx;
    logic [CW-1:0] count, count_nx;
    logic commit, state, state_nx, both, q_nx;
    always_comb begin
        raw = {set_n, clr_n};
        count_nx = (raw != pending) ? CW'(1) : (count == FMAX) ? FMAX : count + CW'(1);
        commit = (count_nx == FMAX) && (raw != cmd);
        cmd_nx = commit ? raw : cmd;
        state_nx = !commit ? state :
                   raw == CMD_SET ? 1'b1 :
                   raw == CMD_CLR ? 1'b0 :
                   raw == CMD_IDLE ? state :
                   MODE == MODE_SET_DOM ? 1'b1 :
                   MODE == MODE_CLR_DOM ? 1'b0 :
                   MODE == MODE_TOGGLE ? ~state : state;
        // NAND mode forces both outputs high while both inputs are committed, leaving state untouched
        both = (MODE == MODE_NAND) && (cmd_nx == CMD_BOTH);
        q_nx = both | state_nx;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= CMD_IDLE;
            count   <= '0;
            cmd     <= CMD_IDLE;
            state   <= 1'b0;
            q       <= 1'b0;
            q_n     <= 1'b1;
            changed <= 1'b0;
            invalid <= 1'b0;
        end else begin
            pending <= raw;
            count   <= count_nx;
            cmd     <= cmd_nx;
            state   <= state_nx;
            q       <= q_nx;
            q_n     <= both | ~state_nx;
            changed <= q_nx ^ q;
            invalid <= both;
        end
    end
endmodule

// File: rtl/sr_latch_bank.sv
// sr_latch_bank: CHANNELS independent filtered SR latches with active-low set/clear
module sr_latch_bank import sr_latch_pkg::*; #(
    parameter int CHANNELS = 4,
    parameter int FILTER_CYCLES = 3,
    parameter int MODE = MODE_NAND
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] set_n,
    input  logic [CHANNELS-1:0] clr_n,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] q_n,
    output logic [CHANNELS-1:0] changed,
    output logic [CHANNELS-1:0] invalid
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sr_latch_channel #(.FILTER_CYCLES(FILTER_CYCLES), .MODE(MODE)) u_ch (
            .clk(clk),
            .reset(reset),
            .set_n(set_n[i]),
            .clr_n(clr_n[i]),
            .q(q[i]),
            .q_n(q_n[i]),
            .changed(changed[i]),
            .invalid(invalid[i])
        );
    end
endmodule

// File: tb/tb_sr_latch_bank.sv
// tb_sr_latch_bank: directed checks of filter, MODE policies, independence and reset
module tb_sr_latch_bank;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] set_n = 4'hf;
    logic [3:0] clr_n = 4'hf;
    logic [3:0] q [4];
    logic [3:0] q_n [4];
    logic [3:0] changed [4];
    logic [3:0] invalid [4];
    logic [3:0] q1, q1_n, changed1, invalid1;
    int total = 0;
    int fails = 0;
    int pulses [4][4];
    logic [3:0] seen [4];
    always #5 clk = ~clk;
    for (genvar m = 0; m < 4; m++) begin : g_dut
        sr_latch_bank #(.CHANNELS(4), .FILTER_CYCLES(3), .MODE(m)) u_dut (
            .clk(clk), .reset(reset), .set_n(set_n), .clr_n(clr_n),
            .q(q[m]), .q_n(q_n[m]), .changed(changed[m]), .invalid(invalid[m])
        );
    end
    sr_latch_bank #(.CHANNELS(4), .FILTER_CYCLES(1), .MODE(0)) u_f1 (
        .clk(clk), .reset(reset), .set_n(set_n), .clr_n(clr_n),
        .q(q1), .q_n(q1_n), .changed(changed1), .invalid(invalid1)
    );
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            for (int m = 0; m < 4; m++) begin
                for (int c = 0; c < 4; c++) pulses[m][c] += int'(changed[m][c]);
                seen[m] |= changed[m];
            end
        end
    endtask
    task automatic clr_stats();
        for (int m = 0; m < 4; m++) begin
            for (int c = 0; c < 4; c++) pulses[m][c] = 0;
            seen[m] = '0;
        end
    endtask
    task automatic test_reset();
        reset = 1'b1;
        cyc(2);
        for (int m = 0; m < 4; m++) begin
            total++;
            if ({q[m], q_n[m], changed[m], invalid[m]} !== 16'h0f00) begin
                fails++;
                $display("FAIL reset mode%0d: got q=%b q_n=%b ch=%b inv=%b want 0000 1111 0000 0000", m, q[m], q_n[m], changed[m], invalid[m]);
            end
        end
        reset = 1'b0;
    endtask
    task automatic test_filter();
        clr_stats();
        set_n = 4'b1110;
        cyc(1);
        total++;
        if (q1[0] !== 1'b1) begin fails++; $display("FAIL f1_latency: got %b want 1", q1[0]); end
        cyc(1);
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m][0] !== 1'b0) begin fails++; $display("FAIL early_commit mode%0d: got %b want 0", m, q[m][0]); end
        end
        cyc(1);
        for (int m = 0; m < 4; m++) begin
            total++;
            if ({q[m][0], changed[m][0]} !== 2'b11) begin fails++; $display("FAIL latency mode%0d: got q=%b ch=%b want 1 1", m, q[m][0], changed[m][0]); end
        end
        cyc(1);
        for (int m = 0; m < 4; m++) begin
            total++;
            if (changed[m][0] !== 1'b0 || pulses[m][0] !== 1) begin fails++; $display("FAIL pulse_width mode%0d: got ch=%b pulses=%0d want 0 1", m, changed[m][0], pulses[m][0]); end
        end
        set_n = 4'hf;
        cyc(3);
        clr_stats();
        set_n = 4'b1101;
        cyc(2);
        set_n = 4'hf;
        cyc(5);
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m][1] !== 1'b0 || seen[m][1] !== 1'b0) begin fails++; $display("FAIL glitch mode%0d: got q=%b seen=%b want 0 0", m, q[m][1], seen[m][1]); end
        end
    endtask
    task automatic test_modes();
        logic [3:0] eq, eqn;
        clr_stats();
        set_n = 4'b1110;
        clr_n = 4'b1110;
        cyc(5);
        eq = 4'b0011;
        eqn = 4'b1101;
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m][0] !== eq[m] || q_n[m][0] !== eqn[m] || invalid[m][0] !== (m == 0)) begin
                fails++;
                $display("FAIL both_from_set mode%0d: got q=%b q_n=%b inv=%b want %b %b %b", m, q[m][0], q_n[m][0], invalid[m][0], eq[m], eqn[m], m == 0);
            end
        end
        total++;
        if (pulses[0][0] !== 0) begin fails++; $display("FAIL nand_entry_pulse: got %0d want 0", pulses[0][0]); end
        set_n = 4'hf;
        clr_n = 4'hf;
        cyc(2);
        total++;
        if (invalid[0][0] !== 1'b1) begin fails++; $display("FAIL invalid_hold: got %b want 1", invalid[0][0]); end
        cyc(1);
        total++;
        if ({q[0][0], q_n[0][0], invalid[0][0]} !== 3'b100) begin fails++; $display("FAIL nand_release_set: got %b want 100", {q[0][0], q_n[0][0], invalid[0][0]}); end
        clr_n = 4'b1110;
        cyc(3);
        clr_n = 4'hf;
        cyc(3);
        clr_stats();
        set_n = 4'b1110;
        clr_n = 4'b1110;
        cyc(5);
        eq = 4'b1011;
        eqn = 4'b0101;
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m][0] !== eq[m] || q_n[m][0] !== eqn[m]) begin
                fails++;
                $display("FAIL both_from_clr mode%0d: got q=%b q_n=%b want %b %b", m, q[m][0], q_n[m][0], eq[m], eqn[m]);
            end
        end
        set_n = 4'hf;
        clr_n = 4'hf;
        cyc(3);
        total++;
        if ({q[0][0], q_n[0][0], invalid[0][0]} !== 3'b010 || pulses[0][0] !== 2) begin
            fails++;
            $display("FAIL nand_release_clr: got %b pulses=%0d want 010 2", {q[0][0], q_n[0][0], invalid[0][0]}, pulses[0][0]);
        end
        total++;
        if (q[1][0] !== 1'b1 || pulses[1][0] !== 1) begin fails++; $display("FAIL set_dom: got q=%b pulses=%0d want 1 1", q[1][0], pulses[1][0]); end
        total++;
        if (q[2][0] !== 1'b0 || pulses[2][0] !== 0) begin fails++; $display("FAIL clr_dom: got q=%b pulses=%0d want 0 0", q[2][0], pulses[2][0]); end
    endtask
    task automatic test_toggle();
        for (int p = 0; p < 3; p++) begin
            set_n = 4'b1011;
            clr_n = 4'b1011;
            cyc(4);
            total++;
            if (q[3][2] !== ((p % 2) == 0)) begin fails++; $display("FAIL toggle_%0d: got %b want %b", p, q[3][2], (p % 2) == 0); end
            set_n = 4'hf;
            clr_n = 4'hf;
            cyc(4);
        end
        clr_stats();
        set_n = 4'b1011;
        clr_n = 4'b1011;
        cyc(20);
        total++;
        if (q[3][2] !== 1'b0 || pulses[3][2] !== 1) begin fails++; $display("FAIL toggle_hold: got q=%b pulses=%0d want 0 1", q[3][2], pulses[3][2]); end
        set_n = 4'hf;
        clr_n = 4'hf;
        cyc(4);
    endtask
    task automatic test_back_to_back();
        set_n = 4'b1101;
        clr_n = 4'b1110;
        cyc(2);
        total++;
        if (q[1][1:0] !== 2'b01) begin fails++; $display("FAIL indep_before: got %b want 01", q[1][1:0]); end
        cyc(1);
        total++;
        if (q[1][1:0] !== 2'b10 || changed[1][1:0] !== 2'b11) begin fails++; $display("FAIL indep_commit: got q=%b ch=%b want 10 11", q[1][1:0], changed[1][1:0]); end
        set_n = 4'hf;
        clr_n = 4'hf;
        cyc(3);
    endtask
    task automatic test_reset_mid();
        set_n = 4'b0111;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        for (int m = 0; m < 4; m++) begin
            total++;
            if ({q[m], q_n[m], changed[m], invalid[m]} !== 16'h0f00) begin
                fails++;
                $display("FAIL mid_reset mode%0d: got q=%b q_n=%b ch=%b inv=%b want 0000 1111 0000 0000", m, q[m], q_n[m], changed[m], invalid[m]);
            end
        end
        cyc(1);
        set_n = 4'hf;
        clr_stats();
        cyc(4);
        for (int m = 0; m < 4; m++) begin
            total++;
            if (q[m] !== 4'b0000 || q_n[m] !== 4'b1111 || seen[m] !== 4'b0000) begin
                fails++;
                $display("FAIL no_commit_after_reset mode%0d: got q=%b q_n=%b seen=%b want 0000 1111 0000", m, q[m], q_n[m], seen[m]);
            end
        end
    endtask
    initial begin
        test_reset();
        test_filter();
        test_modes();
        test_toggle();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/sr_latch_bank.md
Name: sr_latch_bank

Overview:
- Clocked, parametrised successor to our single NAND-style SR latch.
- Holds CHANNELS independent SR state bits with active-low set/clear inputs (idle = both 1, the same convention as the existing latch).
- Each channel has a per-channel stability filter and a selectable policy for simultaneous set+clear.
- Drives q/q_n pairs plus change and invalid flags for downstream status logic.

Parameters:
- CHANNELS, 4, number of independent latch channels (>=1).
- FILTER_CYCLES, 3, consecutive identical samples needed before a command is committed (>=1; 1 = plain registered input).
- MODE, 0, both-asserted policy: 0 = NAND-compatible, 1 = set-dominant, 2 = clear-dominant, 3 = toggle.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- set_n  in  CHANNELS  per-channel set request, active low.
- clr_n  in  CHANNELS  per-channel clear request, active low.
- q  out  CHANNELS  latch output.
- q_n  out  CHANNELS  complementary output (see MODE 0 exception).
- changed  out  CHANNELS  one-cycle pulse when the channel's q changes.
- invalid  out  CHANNELS  high while the channel's committed command is both-asserted in MODE 0.

Behaviour:
- Reset, checked on each clk edge while reset=1, overrides everything.
  - q=0, q_n=1, changed=0, invalid=0.
  - Internal state=0, committed cmd=2'b11 (idle), pending=2'b11, count=0.
- Reset asserted mid-filter discards the partial count. Reset asserted while a toggle is pending discards it.
- Per channel, each edge samples raw={set_n[i],clr_n[i]}.
  - raw==pending: count increments, saturating at FILTER_CYCLES.
  - raw!=pending: pending<=raw, count<=1.
- Commit: cmd<=raw on the edge where raw has now been sampled identically on FILTER_CYCLES consecutive edges (this edge included) and raw!=cmd.
  - Latency from a stable input change to the output update is FILTER_CYCLES edges.
  - Glitches shorter than FILTER_CYCLES samples never commit.
- State update happens on the commit edge, from the new cmd:
  - 2'b01 (set): state<=1.
  - 2'b10 (clear): state<=0.
  - 2'b11 (idle): state holds.
  - 2'b00 (both), by MODE:
    - 0: state holds; outputs forced q=1, q_n=1, invalid=1.
    - 1: state<=1.
    - 2: state<=0.
    - 3: state<=~state, once per commit into 2'b00. Holding 2'b00 does not re-toggle.
- Outputs: q=state and q_n=~state, except MODE 0 while cmd==2'b00.
  - Leaving 2'b00 for 2'b11 in MODE 0 restores the pre-existing state. The race outcome is deterministic: no race.
  - invalid is registered and deasserts on the commit edge leaving 2'b00. It stays 0 in MODES 1-3.
- changed[i]=1 for exactly the one cycle following an edge where q[i] changed; it is registered alongside q. MODE 0 entry into 2'b00 with state=1 produces no pulse, because q stays at 1.
- Channels are fully independent. Simultaneous commits on several channels are all applied on the same edge.
- Count width is $clog2(FILTER_CYCLES+1). No other arithmetic.

Decomposition:
- Package sr_latch_pkg:
  - mode localparams MODE_NAND=0, MODE_SET_DOM=1, MODE_CLR_DOM=2, MODE_TOGGLE=3.
  - command encodings CMD_IDLE=2'b11, CMD_SET=2'b01, CMD_CLR=2'b10, CMD_BOTH=2'b00.
- Sub-module sr_latch_channel (filter + state + flags for one bit, parameters FILTER_CYCLES and MODE), instantiated CHANNELS times in a generate loop.

Test Plan:
- Reset: hold reset 2 cycles with inputs idle -> q=0, q_n=1, changed=0, invalid=0 on all channels.
- Filter latency: FILTER_CYCLES=3, drive set_n[0]=0 stable -> q[0]=1 on the 3rd edge after the change; changed[0]=1 for exactly one cycle. A 2-cycle set_n pulse -> q unchanged, no pulse.
- MODE 0: set, then set_n=clr_n=0 for 5 cycles -> q=1, q_n=1, invalid=1. Release both to 1 -> q=1, q_n=0, invalid=0. Repeat from the cleared state -> q returns to 0 and changed pulses twice in total.
- MODE 1/2: from q=0, drive both asserted -> MODE 1 gives q=1; MODE 2 gives q=0 and no changed pulse.
- MODE 3: three separate 4-cycle both-asserted pulses separated by idle, starting q=0 -> q sequence 1,0,1. A single 20-cycle hold -> exactly one toggle.
- Independence and reset: commit set on ch0 and clear on ch1 in the same cycle -> both update on the same edge. Assert reset 1 cycle into a filter window -> no commit after reset, all outputs at reset values.
